// File: rtl/ru_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ru_pkg
// Brief    : Shared types and constants for the remote-update command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ru_pkg;

    typedef enum logic [1:0] {
        RU_OP_READ     = 2'b00,
        RU_OP_WRITE    = 2'b01,
        RU_OP_RECONFIG = 2'b10,
        RU_OP_RSVD     = 2'b11
    } ru_op_e;

    localparam logic [2:0] c_param_status    = 3'b000;
    localparam logic [2:0] c_param_wdt_value = 3'b010;
    localparam logic [2:0] c_param_wdt_en    = 3'b011;
    localparam logic [2:0] c_param_boot_addr = 3'b100;
    localparam logic [2:0] c_param_anf       = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_RESP    = 3'd4,
        ST_BOOT    = 3'd5
    } ru_state_e;

endpackage
`default_nettype wire

// File: rtl/ru_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ru_timeout_cnt
// Brief    : Wrapping cycle counter; expire marks the edge that reaches LIMIT-1.
// Revision : 1.0 - initial release
// ============================================================================
module ru_timeout_cnt #(
    parameter int LIMIT = 4096,
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WIDTH-1:0] c_hit  = WIDTH'(LIMIT - 2);
    localparam logic [WIDTH-1:0] c_last = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == c_last) ? '0 : r_count + WIDTH'(1);
        end
    end

    // Flag the edge on which the count becomes LIMIT-1, so a consumer can act on it at once.
    assign expire = en && (r_count == c_hit);

endmodule
`default_nettype wire

// File: rtl/ru_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ru_cmd_sequencer
// Brief    : Sequences read/write/reconfig accesses to the remote-update core.
//            Optional watchdog kick generator enabled by RU_WATCHDOG_KICK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ru_cmd_sequencer
    import ru_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int WDOG_PERIOD    = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_param,
    input  logic [1:0]  cmd_source,
    input  logic [23:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [23:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        ru_busy,
    input  logic [23:0] ru_data_out,
    output logic        ru_read_param,
    output logic        ru_write_param,
    output logic [2:0]  ru_param,
    output logic [1:0]  ru_read_source,
    output logic [23:0] ru_data_in,
    output logic        ru_reconfig,
    output logic        ru_reset_timer
);

    ru_state_e   r_state;
    ru_state_e   w_state_nxt;
    ru_op_e      r_op;
    logic [2:0]  r_param;
    logic [1:0]  r_source;
    logic [23:0] r_wdata;
    logic [23:0] r_rdata;
    logic        r_err;
    logic        r_boot_done;
    logic        w_accept;
    logic        w_reject;
    logic        w_tmo_fail;
    logic        w_capture;
    logic        w_tmo_en;
    logic        w_tmo_expire;
    logic        w_drive;

    assign cmd_ready = (r_state == ST_IDLE) && !ru_busy;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_tmo_en  = (r_state == ST_ISSUE) || (r_state == ST_WAIT_LO);

    ru_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (16)
    ) u_tmo_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_accept),
        .en     (w_tmo_en),
        .expire (w_tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_reject       = 1'b0;
        w_tmo_fail     = 1'b0;
        w_capture      = 1'b0;
        w_drive        = 1'b0;
        rsp_valid      = 1'b0;
        rsp_rdata      = '0;
        rsp_err        = 1'b0;
        ru_read_param  = 1'b0;
        ru_write_param = 1'b0;
        ru_param       = '0;
        ru_read_source = '0;
        ru_data_in     = '0;
        ru_reconfig    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (ru_op_e'(cmd_op))
                        RU_OP_READ:     w_state_nxt = ST_ISSUE;
                        RU_OP_WRITE: begin
                            // Status is read-only: refuse without touching the core.
                            if (cmd_param == c_param_status) begin
                                w_state_nxt = ST_RESP;
                                w_reject    = 1'b1;
                            end else begin
                                w_state_nxt = ST_ISSUE;
                            end
                        end
                        RU_OP_RECONFIG: w_state_nxt = ST_BOOT;
                        default: begin
                            w_state_nxt = ST_RESP;
                            w_reject    = 1'b1;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                w_drive        = 1'b1;
                ru_read_param  = (r_op == RU_OP_READ);
                ru_write_param = (r_op == RU_OP_WRITE);
                if (ru_busy) begin
                    w_state_nxt = ST_WAIT_LO;
                end else if (w_tmo_expire) begin
                    w_state_nxt = ST_RESP;
                    w_tmo_fail  = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                w_drive = 1'b1;
                // Busy falling on the expiry cycle still counts as success.
                if (!ru_busy) begin
                    w_state_nxt = ST_SAMPLE;
                    w_capture   = (r_op == RU_OP_READ);
                end else if (w_tmo_expire) begin
                    w_state_nxt = ST_RESP;
                    w_tmo_fail  = 1'b1;
                end
            end
            ST_SAMPLE: w_state_nxt = ST_RESP;
            ST_RESP: begin
                rsp_valid   = 1'b1;
                rsp_rdata   = r_rdata;
                rsp_err     = r_err;
                w_state_nxt = ST_IDLE;
            end
            ST_BOOT: begin
                rsp_valid   = !r_boot_done;
                ru_reconfig = !r_boot_done;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_drive) begin
            ru_param       = r_param;
            ru_read_source = r_source;
            ru_data_in     = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= RU_OP_READ;
            r_param     <= '0;
            r_source    <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_boot_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= ru_op_e'(cmd_op);
                r_param  <= cmd_param;
                r_source <= cmd_source;
                r_wdata  <= cmd_wdata;
                r_rdata  <= '0;
                r_err    <= w_reject;
            end
            if (w_tmo_fail) begin
                r_err <= 1'b1;
            end
            if (w_capture) begin
                r_rdata <= ru_data_out;
            end
            if (r_state == ST_BOOT) begin
                r_boot_done <= 1'b1;
            end
        end
    end

`ifdef RU_WATCHDOG_KICK_EN
    localparam int c_wdog_w = $clog2(WDOG_PERIOD + 1);

    logic w_wdog_en;
    logic w_wdog_expire;
    logic w_kick;
    logic r_kick_pending;

    assign w_wdog_en = (r_state != ST_BOOT);

    ru_timeout_cnt #(
        .LIMIT (WDOG_PERIOD),
        .WIDTH (c_wdog_w)
    ) u_wdog_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .en     (w_wdog_en),
        .expire (w_wdog_expire)
    );

    // A kick due during an access waits for the first idle cycle.
    assign w_kick = r_kick_pending && (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_BOOT)) begin
            r_kick_pending <= 1'b0;
        end else begin
            r_kick_pending <= (r_kick_pending && !w_kick) || w_wdog_expire;
        end
    end

    assign ru_reset_timer = w_kick;
`else
    logic w_unused_wdog;
    assign w_unused_wdog  = (WDOG_PERIOD == 0);
    assign ru_reset_timer = 1'b0;
`endif

endmodule
`default_nettype wire
